// File: rtl/core_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : core_fetch_if
// Purpose  : FETCH-side instruction memory request bus. There is one word
//            read in flight at a time, and it completes on imem_ready.
//            master = fetch stage, slave = memory interface.
// Revision : 1.0 - initial release
// ============================================================================
interface core_fetch_if;
  logic        imem_valid;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_err;

  modport master (
    output imem_valid,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata,
    input  imem_err
  );

  modport slave (
    input  imem_valid,
    input  imem_addr,
    output imem_ready,
    output imem_rdata,
    output imem_err
  );
endinterface
`default_nettype wire

// File: rtl/core_fetch.sv
`default_nettype none
// ============================================================================
// Module   : core_fetch
// Purpose  : Instruction-fetch stage. Holds the PC and issues one word read
//            at a time on the imem bus. Presents the fetched word to DECODE
//            through a single-entry valid/ready register. Handles redirects,
//            including redirects that arrive while a read is in flight.
// Config   : CORE_FETCH_MISALIGN_EN - when defined, a misaligned PC produces
//            a misaligned-fetch fault entry instead of a bus request. When
//            undefined, redirect targets are forced word-aligned and
//            if_misaligned is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module core_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        fetch_en,
  input  wire logic        redirect_valid,
  input  wire logic [31:0] redirect_pc,
  core_fetch_if.master     imem,
  output logic             if_valid,
  input  wire logic        if_ready,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic             if_err,
  output logic             if_misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] addr, addr_nxt;
  logic        kill, kill_nxt;
  logic        req, req_nxt;
  logic        hold_valid, hold_valid_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic        hold_err, hold_err_nxt;
  logic [31:0] target;
  logic        pc_misaligned;

`ifdef CORE_FETCH_MISALIGN_EN
  logic        hold_mis, hold_mis_nxt;

  // A misaligned redirect target is kept as-is so that it can be reported.
  assign target        = redirect_pc;
  assign pc_misaligned = (pc[1:0] != 2'b00);
  assign if_misaligned = hold_mis;
`else
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Without misalignment reporting, the PC can only ever hold word addresses.
  assign target        = redirect_pc & ALIGN_MASK;
  assign pc_misaligned = 1'b0;
  assign if_misaligned = 1'b0;
`endif

  assign imem.imem_valid = req;
  assign imem.imem_addr  = addr;
  assign if_valid        = hold_valid;
  assign if_pc           = hold_pc;
  assign if_instr        = hold_instr;
  assign if_err          = hold_err;

  // Next-state and next-register values. Redirect takes priority in every state.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    kill_nxt       = kill;
    req_nxt        = req;
    hold_valid_nxt = hold_valid;
    hold_pc_nxt    = hold_pc;
    hold_instr_nxt = hold_instr;
    hold_err_nxt   = hold_err;
`ifdef CORE_FETCH_MISALIGN_EN
    hold_mis_nxt   = hold_mis;
`endif
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          pc_nxt = target;
        end else if (fetch_en && pc_misaligned) begin
          // Report the fault locally. No bus request is issued and the PC is unchanged.
          state_nxt      = HOLD;
          hold_valid_nxt = 1'b1;
          hold_pc_nxt    = pc;
          hold_instr_nxt = 32'h0000_0000;
          hold_err_nxt   = 1'b0;
`ifdef CORE_FETCH_MISALIGN_EN
          hold_mis_nxt   = 1'b1;
`endif
        end else if (fetch_en) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
        end
      end
      REQ: begin
        // The request is never withdrawn. A redirect only marks the response as stale.
        if (imem.imem_ready) begin
          req_nxt = 1'b0;
          if (kill || redirect_valid) begin
            kill_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt      = HOLD;
            hold_valid_nxt = 1'b1;
            hold_pc_nxt    = pc;
            hold_instr_nxt = imem.imem_rdata;
            hold_err_nxt   = imem.imem_err;
`ifdef CORE_FETCH_MISALIGN_EN
            hold_mis_nxt   = 1'b0;
`endif
            pc_nxt         = pc + 32'd4;
          end
        end else if (redirect_valid) begin
          kill_nxt = 1'b1;
        end
        if (redirect_valid) begin
          pc_nxt = target;
        end
      end
      HOLD: begin
        // If a redirect arrives in the same cycle as a pop, the pop is ignored.
        if (redirect_valid) begin
          pc_nxt         = target;
          hold_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end else if (if_ready) begin
          hold_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // The bus address stays frozen while a request is outstanding. Otherwise it tracks the PC.
    addr_nxt = (state == REQ && !imem.imem_ready) ? addr : pc_nxt;
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      addr       <= RESET_PC;
      kill       <= 1'b0;
      req        <= 1'b0;
      hold_valid <= 1'b0;
      hold_pc    <= 32'h0000_0000;
      hold_instr <= 32'h0000_0000;
      hold_err   <= 1'b0;
`ifdef CORE_FETCH_MISALIGN_EN
      hold_mis   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      addr       <= addr_nxt;
      kill       <= kill_nxt;
      req        <= req_nxt;
      hold_valid <= hold_valid_nxt;
      hold_pc    <= hold_pc_nxt;
      hold_instr <= hold_instr_nxt;
      hold_err   <= hold_err_nxt;
`ifdef CORE_FETCH_MISALIGN_EN
      hold_mis   <= hold_mis_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_fetch
// Purpose  : Self-checking bench for core_fetch. Directed scenarios are
//            followed by a randomized run that is checked against a
//            program-order reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_err;
  logic        if_misaligned;

  core_fetch_if bus();

  core_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem          (bus),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_err        (if_err),
    .if_misaligned (if_misaligned)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          fixed_wait = 1;
  bit          rand_data = 1'b0;
  logic [31:0] fixed_data = 32'h0000_0013;
  logic [31:0] err_addr = 32'h0000_0001;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return rand_data ? ((a * 32'h0001_0003) ^ 32'h5A5A_1234) : fixed_data;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return rand_data ? (a[6:2] == 5'd9) : (a == err_addr);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder with wait states. It also checks that a pending request is never withdrawn or changed.
  initial begin : responder
    int          wcnt;
    int          wlim;
    logic        rec_v;
    logic        rec_r;
    logic        rec_rst;
    logic [31:0] rec_a;
    wcnt = 0; wlim = 1; rec_v = 1'b0; rec_r = 1'b0; rec_rst = 1'b1; rec_a = 32'h0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.imem_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rec_rst && rec_v && !rec_r) begin
        n_checks++;
        if (bus.imem_valid !== 1'b1 || bus.imem_addr !== rec_a) begin
          n_fail++;
          $display("FAIL imem_hold: got valid=%b addr=%h, want valid=1 addr=%h", bus.imem_valid, bus.imem_addr, rec_a);
        end
      end
      if (rst || bus.imem_valid !== 1'b1 || bus.imem_ready) begin
        bus.imem_ready = 1'b0;
        wcnt = 0;
      end else begin
        wcnt++;
        if (wcnt == 1) wlim = (fixed_wait > 0) ? fixed_wait : 1 + $urandom_range(0, 2);
        if (wcnt > wlim) begin
          bus.imem_ready = 1'b1;
          bus.imem_rdata = data_of(bus.imem_addr);
          bus.imem_err   = err_of(bus.imem_addr);
        end
      end
      rec_v = bus.imem_valid; rec_r = bus.imem_ready; rec_a = bus.imem_addr; rec_rst = rst;
    end
  end

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({bus.imem_valid, bus.imem_addr} !== {1'b0, 32'h8000_0000}) begin
      n_fail++; $display("FAIL reset_bus: got valid=%b addr=%h, want 0/80000000", bus.imem_valid, bus.imem_addr);
    end
    n_checks++;
    if ({if_valid, if_pc, if_instr, if_err, if_misaligned} !== 67'h0) begin
      n_fail++; $display("FAIL reset_out: got v=%b pc=%h instr=%h err=%b mis=%b, want all 0", if_valid, if_pc, if_instr, if_err, if_misaligned);
    end
    rst = 1'b0; fetch_en = 1'b0;
    step();
    n_checks++;
    if (bus.imem_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_fetch: got valid=%b, want 0", bus.imem_valid);
    end
  endtask

  task automatic test_basic();
    fixed_wait = 1; rand_data = 1'b0; fixed_data = 32'h0000_0013;
    fetch_en = 1'b1;
    step();
    n_checks++;
    if ({bus.imem_valid, bus.imem_addr} !== {1'b1, 32'h8000_0000}) begin
      n_fail++; $display("FAIL basic_req: got valid=%b addr=%h, want 1/80000000", bus.imem_valid, bus.imem_addr);
    end
    step();
    n_checks++;
    if ({bus.imem_valid, if_valid} !== 2'b10) begin
      n_fail++; $display("FAIL basic_wait: got valid=%b if_valid=%b, want 1/0", bus.imem_valid, if_valid);
    end
    step();
    n_checks++;
    if ({if_valid, if_pc, if_instr, if_err, bus.imem_valid} !== {1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL basic_entry: got v=%b pc=%h instr=%h err=%b req=%b, want 1/80000000/00000013/0/0", if_valid, if_pc, if_instr, if_err, bus.imem_valid);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    n_checks++;
    if ({if_valid, bus.imem_valid} !== 2'b00) begin
      n_fail++; $display("FAIL pop_idle: got if_valid=%b req=%b, want 0/0", if_valid, bus.imem_valid);
    end
    step();
    n_checks++;
    if ({bus.imem_valid, bus.imem_addr} !== {1'b1, 32'h8000_0004}) begin
      n_fail++; $display("FAIL next_req: got valid=%b addr=%h, want 1/80000004", bus.imem_valid, bus.imem_addr);
    end
    for (int c = 0; c < 20 && if_valid !== 1'b1; c++) step();
    n_checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h8000_0004}) begin
      n_fail++; $display("FAIL next_entry: got v=%b pc=%h, want 1/80000004", if_valid, if_pc);
    end
  endtask

  task automatic test_hold_stall();
    logic [31:0] pc0;
    logic [31:0] in0;
    pc0 = 32'h8000_0004; in0 = 32'h0000_0013;
    fetch_en = 1'b1; if_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if ({if_valid, if_pc, if_instr, bus.imem_valid} !== {1'b1, pc0, in0, 1'b0}) begin
        n_fail++; $display("FAIL hold_stall[%0d]: got v=%b pc=%h instr=%h req=%b, want 1/%h/%h/0", c, if_valid, if_pc, if_instr, bus.imem_valid, pc0, in0);
      end
    end
    fetch_en = 1'b0; if_ready = 1'b1;
    step();
    if_ready = 1'b0;
  endtask

  task automatic test_fault();
    err_addr = 32'h8000_0008; fixed_data = 32'hDEAD_BEEF;
    fetch_en = 1'b1;
    for (int c = 0; c < 20 && if_valid !== 1'b1; c++) step();
    fetch_en = 1'b0;
    n_checks++;
    if ({if_valid, if_err, if_pc, if_instr} !== {1'b1, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL fault_entry: got v=%b err=%b pc=%h instr=%h, want 1/1/80000008/deadbeef", if_valid, if_err, if_pc, if_instr);
    end
    err_addr = 32'h0000_0001;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if ({if_valid, bus.imem_valid, bus.imem_addr} !== {1'b0, 1'b0, 32'h0000_0100}) begin
      n_fail++; $display("FAIL fault_redirect: got v=%b req=%b addr=%h, want 0/0/00000100", if_valid, bus.imem_valid, bus.imem_addr);
    end
    fetch_en = 1'b1;
    step();
    n_checks++;
    if ({bus.imem_valid, bus.imem_addr} !== {1'b1, 32'h0000_0100}) begin
      n_fail++; $display("FAIL fault_refetch: got valid=%b addr=%h, want 1/00000100", bus.imem_valid, bus.imem_addr);
    end
    for (int c = 0; c < 20 && if_valid !== 1'b1; c++) step();
    fetch_en = 1'b0;
    n_checks++;
    if ({if_valid, if_pc, if_err} !== {1'b1, 32'h0000_0100, 1'b0}) begin
      n_fail++; $display("FAIL fault_recover: got v=%b pc=%h err=%b, want 1/00000100/0", if_valid, if_pc, if_err);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
  endtask

  task automatic test_redirect_in_req();
    fixed_wait = 3;
    fetch_en = 1'b1;
    step();
    n_checks++;
    if ({bus.imem_valid, bus.imem_addr} !== {1'b1, 32'h0000_0104}) begin
      n_fail++; $display("FAIL kill_req: got valid=%b addr=%h, want 1/00000104", bus.imem_valid, bus.imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000; fetch_en = 1'b0;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if ({bus.imem_valid, bus.imem_addr} !== {1'b1, 32'h0000_0104}) begin
      n_fail++; $display("FAIL kill_stable: got valid=%b addr=%h, want 1/00000104", bus.imem_valid, bus.imem_addr);
    end
    for (int c = 0; c < 10 && bus.imem_valid === 1'b1; c++) step();
    step();
    n_checks++;
    if ({bus.imem_valid, if_valid} !== 2'b00) begin
      n_fail++; $display("FAIL kill_drop: got req=%b if_valid=%b, want 0/0", bus.imem_valid, if_valid);
    end
    fixed_wait = 1; fetch_en = 1'b1;
    step();
    n_checks++;
    if ({bus.imem_valid, bus.imem_addr} !== {1'b1, 32'h0000_1000}) begin
      n_fail++; $display("FAIL kill_newreq: got valid=%b addr=%h, want 1/00001000", bus.imem_valid, bus.imem_addr);
    end
    for (int c = 0; c < 20 && if_valid !== 1'b1; c++) step();
    fetch_en = 1'b0;
    n_checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h0000_1000}) begin
      n_fail++; $display("FAIL kill_entry: got v=%b pc=%h, want 1/00001000", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect_pop();
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    step();
    if_ready = 1'b0; redirect_valid = 1'b0;
    n_checks++;
    if ({if_valid, bus.imem_addr} !== {1'b0, 32'h0000_2000}) begin
      n_fail++; $display("FAIL popredir: got v=%b addr=%h, want 0/00002000", if_valid, bus.imem_addr);
    end
    fetch_en = 1'b1;
    step();
    n_checks++;
    if ({bus.imem_valid, bus.imem_addr} !== {1'b1, 32'h0000_2000}) begin
      n_fail++; $display("FAIL popredir_req: got valid=%b addr=%h, want 1/00002000", bus.imem_valid, bus.imem_addr);
    end
    for (int c = 0; c < 20 && if_valid !== 1'b1; c++) step();
    fetch_en = 1'b0;
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; fetch_en = 1'b1;
    for (int c = 0; c < 20 && if_valid !== 1'b1; c++) step();
    n_checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++; $display("FAIL wrap_entry: got v=%b pc=%h, want 1/fffffffc", if_valid, if_pc);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    for (int c = 0; c < 20 && bus.imem_valid !== 1'b1; c++) step();
    n_checks++;
    if ({bus.imem_valid, bus.imem_addr} !== {1'b1, 32'h0000_0000}) begin
      n_fail++; $display("FAIL wrap_req: got valid=%b addr=%h, want 1/00000000", bus.imem_valid, bus.imem_addr);
    end
    for (int c = 0; c < 20 && if_valid !== 1'b1; c++) step();
    fetch_en = 1'b0; if_ready = 1'b1;
    step();
    if_ready = 1'b0;
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
`ifdef CORE_FETCH_MISALIGN_EN
    fetch_en = 1'b1;
    step();
    n_checks++;
    if ({bus.imem_valid, if_valid, if_misaligned, if_pc, if_instr, if_err} !== {1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL misalign_entry: got req=%b v=%b mis=%b pc=%h instr=%h err=%b, want 0/1/1/00000102/0/0", bus.imem_valid, if_valid, if_misaligned, if_pc, if_instr, if_err);
    end
    step();
    n_checks++;
    if ({bus.imem_valid, if_valid} !== 2'b01) begin
      n_fail++; $display("FAIL misalign_hold: got req=%b v=%b, want 0/1", bus.imem_valid, if_valid);
    end
    fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
    step();
    redirect_valid = 1'b0;
`else
    n_checks++;
    if (bus.imem_addr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL align_force: got addr=%h, want 00000100", bus.imem_addr);
    end
    fetch_en = 1'b1;
    for (int c = 0; c < 20 && if_valid !== 1'b1; c++) step();
    fetch_en = 1'b0;
    n_checks++;
    if ({if_valid, if_pc, if_misaligned} !== {1'b1, 32'h0000_0100, 1'b0}) begin
      n_fail++; $display("FAIL align_entry: got v=%b pc=%h mis=%b, want 1/00000100/0", if_valid, if_pc, if_misaligned);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    fixed_wait = 3; fetch_en = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; fetch_en = 1'b0;
    n_checks++;
    if ({bus.imem_valid, bus.imem_addr, if_valid} !== {1'b0, 32'h8000_0000, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid: got req=%b addr=%h v=%b, want 0/80000000/0", bus.imem_valid, bus.imem_addr, if_valid);
    end
    step();
  endtask

  // Randomized traffic. The model keeps only the architectural PC of the next instruction DECODE should see.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] r;
    int          redir_cnt;
    int          req_tag;
    int          pops;
    logic        prev_v;
    exp_pc = 32'h8000_0000; redir_cnt = 0; req_tag = -1; pops = 0; prev_v = 1'b0;
    rand_data = 1'b1; fixed_wait = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.imem_valid === 1'b1 && !prev_v) req_tag = redir_cnt;
      prev_v = (bus.imem_valid === 1'b1);
      redirect_valid = ($urandom_range(0, 99) < 4);
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      redirect_pc = r;
      fetch_en = ($urandom_range(0, 99) < 85);
      if_ready = ($urandom_range(0, 99) < 60);
      if (bus.imem_valid === 1'b1 && bus.imem_ready && req_tag == redir_cnt) begin
        n_checks++;
        if (bus.imem_addr !== exp_pc) begin
          n_fail++; $display("FAIL rand_addr[%0d]: got %h, want %h", i, bus.imem_addr, exp_pc);
        end
      end
      if (if_valid === 1'b1 && if_ready && !redirect_valid) begin
        pops++;
        n_checks++;
        if (exp_pc[1:0] != 2'b00) begin
          if ({if_pc, if_instr, if_err, if_misaligned} !== {exp_pc, 32'h0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rand_mis[%0d]: got pc=%h instr=%h err=%b mis=%b, want %h/0/0/1", i, if_pc, if_instr, if_err, if_misaligned, exp_pc);
          end
        end else begin
          if ({if_pc, if_instr, if_err, if_misaligned} !== {exp_pc, data_of(exp_pc), err_of(exp_pc), 1'b0}) begin
            n_fail++; $display("FAIL rand_pop[%0d]: got pc=%h instr=%h err=%b mis=%b, want %h/%h/%b/0", i, if_pc, if_instr, if_err, if_misaligned, exp_pc, data_of(exp_pc), err_of(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redirect_valid) begin
`ifdef CORE_FETCH_MISALIGN_EN
        exp_pc = r;
`else
        exp_pc = {r[31:2], 2'b00};
`endif
        redir_cnt++;
      end
      step();
    end
    redirect_valid = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
    n_checks++;
    if (pops < 50) begin
      n_fail++; $display("FAIL rand_progress: got %0d pops, want at least 50", pops);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_basic();
    test_hold_stall();
    test_fault();
    test_redirect_in_req();
    test_redirect_pop();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
